aqua_multicanal_uc: RTL and testbench
=====================================

AQUA_MULTICANAL_UC -- requirements
Module: aqua_multicanal_uc

Interface
REQ-001 SHALL have parameter N_CANAIS, default 4, number of monitored tanks (1..16).
REQ-002 SHALL have parameter T_MEDIDA, default 50_000_000, max clock cycles allowed per level measurement.
REQ-003 SHALL have parameter T_VALVULA, default 50_000_000, valve settle cycles after any actuation.
REQ-004 SHALL have parameter T_INTERVALO, default 100_000_000, idle cycles between full scans.
REQ-005 SHALL have ports: clock in 1 system clock; reset in 1 asynchronous active-high reset; clock clock.
REQ-006 SHALL have ports: iniciar in 1 level-sensitive run enable; fim_medida in 1 measurement-done pulse; descartar in 1 measurement-invalid pulse.
REQ-007 SHALL have ports: classificacao in 3 level class; classificacao_valida in 1 class-qualified strobe; fim_caracter in 1 UART char done; fim_mensagem in 1 last char flag.
REQ-008 SHALL have ports: canal out clog2(N_CANAIS) (min 1) selected tank; mede out 1 measurement request; analisa out 1 classifier enable.
REQ-009 SHALL have ports: valvulas out N_CANAIS per-tank valve state; buzzer_alta out N_CANAIS; buzzer_baixa out N_CANAIS; envia out 1; muda out 1; pronto out 1; erro_timeout out N_CANAIS sticky; db_estado out 4.

Function
REQ-010 SHALL implement states INICIAL(0), ZERA(1), OCIOSO(2), SELECIONA(3), MEDE(4), ANALISA(5), ATUA(6), ESPERA_VLV(7), ENVIA(8), MUDA(9), PROXIMO(10), INTERVALO(11); db_estado = state code; unused codes -> INICIAL.
REQ-011 SHALL go INICIAL->ZERA when iniciar=1; ZERA clears valvulas, buzzers, erro_timeout, canal=0, then OCIOSO.
REQ-012 SHALL go OCIOSO->SELECIONA when iniciar=1, else hold; SELECIONA resets measurement timer, then MEDE.
REQ-013 SHALL assert mede in MEDE; fim_medida -> ANALISA; descartar -> PROXIMO; timer reaching T_MEDIDA-1 -> set erro_timeout[canal], PROXIMO; fim_medida wins over simultaneous timeout.
REQ-014 SHALL assert analisa in ANALISA; exit only on classificacao_valida; descartar has priority -> PROXIMO; codes 000/101-111 with strobe -> hold ANALISA.
REQ-015 SHALL in ATUA, for tank canal: 001 buzzer_baixa=1, buzzer_alta=0, close valve; 010 buzzer_alta=1, buzzer_baixa=0, valve unchanged; 011 buzzer_alta=1, open valve; 100 both buzzers 0, close valve; a successful valid measurement clears erro_timeout[canal].
REQ-016 SHALL go ATUA->ESPERA_VLV only if valvulas[canal] actually changes, else ATUA->ENVIA.
REQ-017 SHALL hold ESPERA_VLV exactly T_VALVULA cycles then ENVIA.
REQ-018 SHALL assert envia in ENVIA; fim_caracter with fim_mensagem -> PROXIMO; fim_caracter alone -> MUDA; MUDA is one cycle with muda=1 -> ENVIA.
REQ-019 SHALL in PROXIMO increment canal; at N_CANAIS-1 wrap to 0 and go INTERVALO, else SELECIONA.
REQ-020 SHALL assert pronto throughout INTERVALO; after T_INTERVALO cycles -> OCIOSO.
REQ-021 SHALL, when iniciar=0 in any state except INICIAL/ZERA/ESPERA_VLV, go OCIOSO next cycle, preserving valvulas/buzzers; ESPERA_VLV completes first.
REQ-022 SHALL register all outputs except mede/analisa/envia/muda/pronto, which decode the current state.

Reset
REQ-023 SHALL on reset set state INICIAL, canal 0, valvulas 0, buzzers 0, erro_timeout 0, all timers 0, all strobes 0, asynchronously, mid-operation included.

Configuration
REQ-024 SHALL, with AQUA_HISTERESE_EN defined, close an open valve on class 100 only after two consecutive 100 results for that tank (per-tank 1-bit flag, cleared by any other class or ZERA); without it, close on the first 100.

Structure
REQ-025 SHALL place state codes and classification codes (CLS_BAIXA=001, CLS_ALTA=010, CLS_MUITO_ALTA=011, CLS_NORMAL=100) in package aqua_pkg.
REQ-026 SHALL instantiate one sub-module aqua_temporizador (parametrised down-counter with load/fim) for the three timers.

Verification
REQ-027 SHALL test N_CANAIS=4, T_*=8: tank 2 class 011 -> valvulas=0100, ESPERA_VLV 8 cycles, buzzer_alta[2]=1.
REQ-028 SHALL test tank 1 fim_medida absent -> erro_timeout=0010 after 8 MEDE cycles, canal advances to 2.
REQ-029 SHALL test tank 3 last in scan -> canal wraps 0, pronto high 8 cycles, then OCIOSO.
REQ-030 SHALL test AQUA_HISTERESE_EN: open valve tank 0, class 100 once -> still open; twice -> closed; macro off -> closed first time.
REQ-031 SHALL test reset asserted in ENVIA -> db_estado=0, valvulas=0 same cycle.
REQ-032 SHALL test iniciar dropped in ANALISA -> OCIOSO next cycle, valvulas unchanged.

Source files
------------

// File: rtl/aqua_pkg.sv
// Shared definitions for the multi-tank water level controller:
// FSM state codes, level classification codes and a class check helper.
package aqua_pkg;

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        ZERA       = 4'd1,
        OCIOSO     = 4'd2,
        SELECIONA  = 4'd3,
        MEDE       = 4'd4,
        ANALISA    = 4'd5,
        ATUA       = 4'd6,
        ESPERA_VLV = 4'd7,
        ENVIA      = 4'd8,
        MUDA       = 4'd9,
        PROXIMO    = 4'd10,
        INTERVALO  = 4'd11
    } estado_t;

    localparam logic [2:0] CLS_BAIXA      = 3'b001;
    localparam logic [2:0] CLS_ALTA       = 3'b010;
    localparam logic [2:0] CLS_MUITO_ALTA = 3'b011;
    localparam logic [2:0] CLS_NORMAL     = 3'b100;

    // Only the four defined classes move the FSM out of ANALISA.
    function automatic logic cls_conhecida(input logic [2:0] cls);
        return (cls == CLS_BAIXA) || (cls == CLS_ALTA) ||
               (cls == CLS_MUITO_ALTA) || (cls == CLS_NORMAL);
    endfunction

endpackage

// File: rtl/aqua_temporizador.sv
// Parametrised down-counter used for the measurement, valve settle and
// scan interval timers. carrega loads T-1; conta decrements toward zero;
// fim flags a count of zero, so a timer loaded and then counted for T
// cycles raises fim in its T-th counting cycle.
module aqua_temporizador #(
    parameter int unsigned T = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic carrega,
    input  logic conta,
    output logic fim
);

    localparam int W = (T > 1) ? $clog2(T) : 1;
    localparam logic [W-1:0] CARGA = W'(T - 1);

    logic [W-1:0] contagem;

    // Load has priority over counting; counter parks at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= '0;
        end else if (carrega) begin
            contagem <= CARGA;
        end else if (conta && (contagem != '0)) begin
            contagem <= contagem - W'(1);
        end
    end

    assign fim = (contagem == '0);

endmodule

// File: rtl/aqua_multicanal_uc.sv
// Control unit for a multi-tank level monitor. Scans each tank in turn:
// request a measurement, wait for a classification, drive that tank's
// buzzers and valve, let the valve settle, report over UART, then move on.
// After a full scan it idles for an interval with pronto high.
//
// Optional build macro: AQUA_HISTERESE_EN -- an open valve is closed on a
// NORMAL class only after two consecutive NORMAL results for that tank.
//
// state      | meaning
// INICIAL    | power-up, waits for iniciar
// ZERA       | clears valves, buzzers, errors, channel
// OCIOSO     | idle, waits for iniciar
// SELECIONA  | arms measurement timer for current tank
// MEDE       | measurement requested, timeout running
// ANALISA    | classifier enabled, waits for a known class
// ATUA       | applies class to buzzers/valve of current tank
// ESPERA_VLV | valve settle time, cannot be aborted
// ENVIA      | UART character in flight
// MUDA       | one-cycle advance to next character
// PROXIMO    | next tank or end of scan
// INTERVALO  | idle time between scans, pronto high
module aqua_multicanal_uc
    import aqua_pkg::*;
#(
    parameter int unsigned N_CANAIS    = 4,
    parameter int unsigned T_MEDIDA    = 50_000_000,
    parameter int unsigned T_VALVULA   = 50_000_000,
    parameter int unsigned T_INTERVALO = 100_000_000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    iniciar,
    input  logic                    fim_medida,
    input  logic                    descartar,
    input  logic [2:0]              classificacao,
    input  logic                    classificacao_valida,
    input  logic                    fim_caracter,
    input  logic                    fim_mensagem,
    output logic [((N_CANAIS > 1) ? $clog2(N_CANAIS) : 1)-1:0] canal,
    output logic                    mede,
    output logic                    analisa,
    output logic [N_CANAIS-1:0]     valvulas,
    output logic [N_CANAIS-1:0]     buzzer_alta,
    output logic [N_CANAIS-1:0]     buzzer_baixa,
    output logic                    envia,
    output logic                    muda,
    output logic                    pronto,
    output logic [N_CANAIS-1:0]     erro_timeout,
    output logic [3:0]              db_estado
);

    localparam int CW = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(N_CANAIS - 1);

    estado_t    estado;
    logic [2:0] cls_reg;

    logic fim_t_medida;
    logic fim_t_valvula;
    logic fim_t_intervalo;

    logic abortar;
    logic vlv_nova;
    logic alta_nova;
    logic baixa_nova;

`ifdef AQUA_HISTERESE_EN
    logic [N_CANAIS-1:0] histerese;
    logic                hist_novo;
`endif

    aqua_temporizador #(.T(T_MEDIDA)) u_t_medida (
        .clock   (clock),
        .reset   (reset),
        .carrega (estado == SELECIONA),
        .conta   (estado == MEDE),
        .fim     (fim_t_medida)
    );

    aqua_temporizador #(.T(T_VALVULA)) u_t_valvula (
        .clock   (clock),
        .reset   (reset),
        .carrega (estado == ATUA),
        .conta   (estado == ESPERA_VLV),
        .fim     (fim_t_valvula)
    );

    aqua_temporizador #(.T(T_INTERVALO)) u_t_intervalo (
        .clock   (clock),
        .reset   (reset),
        .carrega (estado == PROXIMO),
        .conta   (estado == INTERVALO),
        .fim     (fim_t_intervalo)
    );

    // Dropping iniciar returns to idle except during setup and valve settling.
    always_comb begin
        abortar = 1'b0;
        if (!iniciar) begin
            case (estado)
                SELECIONA, MEDE, ANALISA, ATUA, ENVIA, MUDA, PROXIMO, INTERVALO:
                    abortar = 1'b1;
                default:
                    abortar = 1'b0;
            endcase
        end
    end

    // New buzzer/valve values for the current tank given the latched class.
    always_comb begin
        vlv_nova   = valvulas[canal];
        alta_nova  = buzzer_alta[canal];
        baixa_nova = buzzer_baixa[canal];
`ifdef AQUA_HISTERESE_EN
        hist_novo  = 1'b0;
`endif
        case (cls_reg)
            CLS_BAIXA: begin
                baixa_nova = 1'b1;
                alta_nova  = 1'b0;
                vlv_nova   = 1'b0;
            end
            CLS_ALTA: begin
                alta_nova  = 1'b1;
                baixa_nova = 1'b0;
            end
            CLS_MUITO_ALTA: begin
                alta_nova  = 1'b1;
                baixa_nova = 1'b0;
                vlv_nova   = 1'b1;
            end
            CLS_NORMAL: begin
                alta_nova  = 1'b0;
                baixa_nova = 1'b0;
`ifdef AQUA_HISTERESE_EN
                hist_novo  = 1'b1;
                if (histerese[canal]) begin
                    vlv_nova = 1'b0;
                end
`else
                vlv_nova   = 1'b0;
`endif
            end
            default: begin
                vlv_nova   = valvulas[canal];
            end
        endcase
    end

    // Main sequencer: state, channel, per-tank outputs and sticky errors.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado       <= INICIAL;
            canal        <= '0;
            cls_reg      <= '0;
            valvulas     <= '0;
            buzzer_alta  <= '0;
            buzzer_baixa <= '0;
            erro_timeout <= '0;
`ifdef AQUA_HISTERESE_EN
            histerese    <= '0;
`endif
        end else if (abortar) begin
            estado <= OCIOSO;
        end else begin
            case (estado)
                INICIAL: begin
                    if (iniciar) estado <= ZERA;
                end
                ZERA: begin
                    valvulas     <= '0;
                    buzzer_alta  <= '0;
                    buzzer_baixa <= '0;
                    erro_timeout <= '0;
                    canal        <= '0;
`ifdef AQUA_HISTERESE_EN
                    histerese    <= '0;
`endif
                    estado       <= OCIOSO;
                end
                OCIOSO: begin
                    if (iniciar) estado <= SELECIONA;
                end
                SELECIONA: begin
                    estado <= MEDE;
                end
                MEDE: begin
                    if (fim_medida) begin
                        estado <= ANALISA;
                    end else if (descartar) begin
                        estado <= PROXIMO;
                    end else if (fim_t_medida) begin
                        erro_timeout[canal] <= 1'b1;
                        estado              <= PROXIMO;
                    end
                end
                ANALISA: begin
                    if (descartar) begin
                        estado <= PROXIMO;
                    end else if (classificacao_valida && cls_conhecida(classificacao)) begin
                        cls_reg <= classificacao;
                        estado  <= ATUA;
                    end
                end
                ATUA: begin
                    valvulas[canal]     <= vlv_nova;
                    buzzer_alta[canal]  <= alta_nova;
                    buzzer_baixa[canal] <= baixa_nova;
                    erro_timeout[canal] <= 1'b0;
`ifdef AQUA_HISTERESE_EN
                    histerese[canal]    <= hist_novo && !vlv_nova ? 1'b0 : hist_novo;
`endif
                    estado <= (vlv_nova != valvulas[canal]) ? ESPERA_VLV : ENVIA;
                end
                ESPERA_VLV: begin
                    if (fim_t_valvula) estado <= ENVIA;
                end
                ENVIA: begin
                    if (fim_caracter) begin
                        estado <= fim_mensagem ? PROXIMO : MUDA;
                    end
                end
                MUDA: begin
                    estado <= ENVIA;
                end
                PROXIMO: begin
                    if (canal == ULTIMO) begin
                        canal  <= '0;
                        estado <= INTERVALO;
                    end else begin
                        canal  <= canal + CW'(1);
                        estado <= SELECIONA;
                    end
                end
                INTERVALO: begin
                    if (fim_t_intervalo) estado <= OCIOSO;
                end
                default: begin
                    estado <= INICIAL;
                end
            endcase
        end
    end

    // Strobes decode the current state; db_estado mirrors the state register.
    assign mede      = (estado == MEDE);
    assign analisa   = (estado == ANALISA);
    assign envia     = (estado == ENVIA);
    assign muda      = (estado == MUDA);
    assign pronto    = (estado == INTERVALO);
    assign db_estado = 4'(estado);

endmodule

// File: tb/tb_aqua_multicanal_uc.sv
// Directed bench for aqua_multicanal_uc with N_CANAIS=4 and all timers 8.
// Expectations for the NORMAL-class valve closing follow AQUA_HISTERESE_EN.
module tb_aqua_multicanal_uc;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       fim_medida = 1'b0;
    logic       descartar = 1'b0;
    logic [2:0] classificacao = 3'b000;
    logic       classificacao_valida = 1'b0;
    logic       fim_caracter = 1'b0;
    logic       fim_mensagem = 1'b0;
    logic [1:0] canal;
    logic       mede, analisa, envia, muda, pronto;
    logic [3:0] valvulas, buzzer_alta, buzzer_baixa, erro_timeout;
    logic [3:0] db_estado;

    int checks = 0;
    int failures = 0;

    aqua_multicanal_uc #(
        .N_CANAIS(4), .T_MEDIDA(8), .T_VALVULA(8), .T_INTERVALO(8)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .fim_medida(fim_medida), .descartar(descartar),
        .classificacao(classificacao), .classificacao_valida(classificacao_valida),
        .fim_caracter(fim_caracter), .fim_mensagem(fim_mensagem),
        .canal(canal), .mede(mede), .analisa(analisa), .valvulas(valvulas),
        .buzzer_alta(buzzer_alta), .buzzer_baixa(buzzer_baixa),
        .envia(envia), .muda(muda), .pronto(pronto),
        .erro_timeout(erro_timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // From SELECIONA: measure, classify with cls, stop right after ATUA.
    task automatic medir(input logic [2:0] cls);
        tick();
        check("medir_mede", 32'(mede), 32'd1);
        fim_medida = 1'b1;
        tick();
        fim_medida = 1'b0;
        check("medir_analisa", 32'(analisa), 32'd1);
        classificacao = cls;
        classificacao_valida = 1'b1;
        tick();
        classificacao_valida = 1'b0;
        check("medir_atua", 32'(db_estado), 32'd6);
        tick();
    endtask

    // From ENVIA: last character, then PROXIMO, then the next state.
    task automatic envia_fim();
        fim_caracter = 1'b1;
        fim_mensagem = 1'b1;
        tick();
        fim_caracter = 1'b0;
        fim_mensagem = 1'b0;
        check("envia_fim_proximo", 32'(db_estado), 32'd10);
        tick();
    endtask

    // From SELECIONA: discard the measurement and move on.
    task automatic descarta();
        tick();
        descartar = 1'b1;
        tick();
        descartar = 1'b0;
        check("descarta_proximo", 32'(db_estado), 32'd10);
        tick();
    endtask

    // From first INTERVALO cycle: 8 cycles, OCIOSO, then SELECIONA on tank 0.
    task automatic fim_intervalo();
        repeat (8) tick();
        check("intervalo_ocioso", 32'(db_estado), 32'd2);
        tick();
        check("intervalo_seleciona", 32'(db_estado), 32'd3);
        check("intervalo_canal0", 32'(canal), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_estado", 32'(db_estado), 32'd0);
        check("rst_valvulas", 32'(valvulas), 32'd0);
        check("rst_canal", 32'(canal), 32'd0);
        check("rst_erro", 32'(erro_timeout), 32'd0);
        check("rst_buzzers", 32'({buzzer_alta, buzzer_baixa}), 32'd0);
        check("rst_strobes", 32'({mede, analisa, envia, muda, pronto}), 32'd0);

        reset = 1'b0;
        tick();
        check("inicial_hold", 32'(db_estado), 32'd0);
        iniciar = 1'b1;
        tick();
        check("zera", 32'(db_estado), 32'd1);
        tick();
        check("ocioso", 32'(db_estado), 32'd2);
        tick();
        check("seleciona", 32'(db_estado), 32'd3);

        // Scan 1, tank 0: BAIXA, valve already closed -> straight to ENVIA.
        medir(3'b001);
        check("t0_envia", 32'(db_estado), 32'd8);
        check("t0_baixa", 32'(buzzer_baixa), 32'b0001);
        check("t0_valv", 32'(valvulas), 32'd0);
        fim_caracter = 1'b1;
        tick();
        fim_caracter = 1'b0;
        check("muda_estado", 32'(db_estado), 32'd9);
        check("muda_strobe", 32'(muda), 32'd1);
        tick();
        check("muda_volta_envia", 32'(envia), 32'd1);
        envia_fim();
        check("t1_canal", 32'(canal), 32'd1);

        // Tank 1: no fim_medida -> timeout after 8 MEDE cycles.
        tick();
        check("t1_mede", 32'(db_estado), 32'd4);
        repeat (7) tick();
        check("t1_mede_ultimo", 32'(db_estado), 32'd4);
        tick();
        check("t1_proximo", 32'(db_estado), 32'd10);
        check("t1_erro", 32'(erro_timeout), 32'b0010);
        tick();
        check("t2_canal", 32'(canal), 32'd2);
        check("t2_seleciona", 32'(db_estado), 32'd3);

        // Tank 2: undefined classes hold ANALISA, then MUITO_ALTA opens valve.
        tick();
        fim_medida = 1'b1;
        tick();
        fim_medida = 1'b0;
        classificacao = 3'b000;
        classificacao_valida = 1'b1;
        tick();
        check("t2_cls000_hold", 32'(db_estado), 32'd5);
        classificacao = 3'b111;
        tick();
        check("t2_cls111_hold", 32'(db_estado), 32'd5);
        classificacao = 3'b011;
        tick();
        classificacao_valida = 1'b0;
        check("t2_atua", 32'(db_estado), 32'd6);
        tick();
        check("t2_espera", 32'(db_estado), 32'd7);
        check("t2_valv", 32'(valvulas), 32'b0100);
        check("t2_alta", 32'(buzzer_alta), 32'b0100);
        repeat (7) tick();
        check("t2_espera_ultimo", 32'(db_estado), 32'd7);
        tick();
        check("t2_envia", 32'(db_estado), 32'd8);
        envia_fim();
        check("t3_canal", 32'(canal), 32'd3);

        // Tank 3: last in scan -> wrap and interval.
        descarta();
        check("wrap_intervalo", 32'(db_estado), 32'd11);
        check("wrap_canal", 32'(canal), 32'd0);
        check("wrap_pronto", 32'(pronto), 32'd1);
        repeat (7) tick();
        check("pronto_ultimo", 32'(pronto), 32'd1);
        tick();
        check("pos_intervalo_ocioso", 32'(db_estado), 32'd2);
        check("pos_intervalo_pronto", 32'(pronto), 32'd0);
        tick();
        check("scan2_seleciona", 32'(db_estado), 32'd3);

        // Scan 2, tank 0: open valve.
        medir(3'b011);
        check("s2t0_espera", 32'(db_estado), 32'd7);
        check("s2t0_valv", 32'(valvulas), 32'b0101);
        repeat (8) tick();
        check("s2t0_envia", 32'(db_estado), 32'd8);
        envia_fim();

        // Tank 1: iniciar dropped in ANALISA.
        tick();
        fim_medida = 1'b1;
        tick();
        fim_medida = 1'b0;
        check("s2t1_analisa", 32'(db_estado), 32'd5);
        iniciar = 1'b0;
        tick();
        check("abort_ocioso", 32'(db_estado), 32'd2);
        check("abort_valv", 32'(valvulas), 32'b0101);
        check("abort_canal", 32'(canal), 32'd1);
        iniciar = 1'b1;
        tick();
        check("retoma_seleciona", 32'(db_estado), 32'd3);
        descarta();
        descarta();
        descarta();
        check("s2_intervalo", 32'(db_estado), 32'd11);
        fim_intervalo();

        // Scan 3, tank 0: first NORMAL.
        medir(3'b100);
`ifdef AQUA_HISTERESE_EN
        check("normal1_estado", 32'(db_estado), 32'd8);
        check("normal1_valv", 32'(valvulas), 32'b0101);
`else
        check("normal1_estado", 32'(db_estado), 32'd7);
        check("normal1_valv", 32'(valvulas), 32'b0100);
        repeat (8) tick();
`endif
        check("normal1_alta", 32'(buzzer_alta), 32'b0100);
        envia_fim();
        descarta();
        descarta();
        descarta();
        fim_intervalo();

        // Scan 4, tank 0: second NORMAL closes in either build.
        medir(3'b100);
        check("normal2_valv", 32'(valvulas), 32'b0100);
`ifdef AQUA_HISTERESE_EN
        check("normal2_estado", 32'(db_estado), 32'd7);
        repeat (8) tick();
`else
        check("normal2_estado", 32'(db_estado), 32'd8);
`endif
        check("normal2_envia", 32'(db_estado), 32'd8);

        // Asynchronous reset in ENVIA.
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_estado", 32'(db_estado), 32'd0);
        check("rst_async_valv", 32'(valvulas), 32'd0);
        check("rst_async_alta", 32'(buzzer_alta), 32'd0);
        check("rst_async_envia", 32'(envia), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
